multi_port_reg_file: RTL and testbench

Parametrised register file: generalises the fixed 64x64, 4-read/2-write register file to any width, depth and read/write port count. Adds per-port enables, registered read data with valid, write-first bypass and write-collision detection. Sits beside the datapath as the architectural register store; read data feeds operand latches.

---
 rtl/multi_port_reg_file_pkg.sv | 41 ++++
 rtl/multi_port_reg_file_read_port.sv | 49 ++++
 rtl/multi_port_reg_file.sv | 85 ++++++++
 tb/tb_multi_port_reg_file.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_port_reg_file_pkg.sv
// Shared constants, address-vector types and write-port arbitration helpers
// for the parametrised multi-port register file.
package multi_port_reg_file_pkg;

    localparam int DEF_WIDTH  = 64;
    localparam int DEF_DEPTH  = 64;
    localparam int DEF_NUM_RD = 4;
    localparam int DEF_NUM_WR = 2;

    // Write-port vectors are zero-extended to these maxima so the helpers stay parameter-free.
    localparam int MAX_WR = 4;
    localparam int MAX_AW = 32;

    typedef logic [MAX_AW-1:0]             addr_t;
    typedef logic [MAX_WR-1:0][MAX_AW-1:0] addr_vec_t;

    // Highest-index enabled port hitting addr, or -1 when no port writes it.
    function automatic int win_port(input logic [MAX_WR-1:0] we,
                                    input addr_vec_t waddr,
                                    input addr_t addr);
        int w;
        w = -1;
        for (int i = 0; i < MAX_WR; i++) begin
            if (we[i] && (waddr[i] == addr)) w = i;
        end
        return w;
    endfunction

    // Number of enabled write ports targeting addr.
    function automatic int count_matches(input logic [MAX_WR-1:0] we,
                                         input addr_vec_t waddr,
                                         input addr_t addr);
        int n;
        n = 0;
        for (int i = 0; i < MAX_WR; i++) begin
            if (we[i] && (waddr[i] == addr)) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/multi_port_reg_file_read_port.sv
// One registered read port: entry mux, write-first bypass and rdata/rvalid flops.
// MULTI_PORT_REG_FILE_ZERO_REG_EN forces reads of address 0 to zero.
module reg_file_read_port
    import multi_port_reg_file_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_WR = DEF_NUM_WR,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          re,
    input  logic [AW-1:0]                 raddr,
    input  logic [DEPTH-1:0][WIDTH-1:0]   mem,
    input  logic [MAX_WR-1:0]             we_vec,
    input  addr_vec_t                     wa_vec,
    input  logic [NUM_WR*WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]              rdata,
    output logic                          rvalid
);

    int               win;
    logic [WIDTH-1:0] next_data;

    always_comb begin
        win       = win_port(we_vec, wa_vec, addr_t'(raddr));
        next_data = mem[raddr];
        for (int i = 0; i < NUM_WR; i++) begin
            if (win == i) next_data = wdata[i*WIDTH +: WIDTH];
        end
`ifdef MULTI_PORT_REG_FILE_ZERO_REG_EN
        if (raddr == '0) next_data = '0;
`endif
    end

    // rvalid is high for exactly the cycle after an enabled read edge; there is
    // no ready, reads never stall, and rdata holds while re is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) rdata <= next_data;
        end
    end

endmodule

// File: rtl/multi_port_reg_file.sv
// Parametrised register file with NUM_WR write ports and NUM_RD registered read ports.
// Define MULTI_PORT_REG_FILE_ZERO_REG_EN to hardwire entry 0 to zero.
module multi_port_reg_file
    import multi_port_reg_file_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int NUM_WR = DEF_NUM_WR
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_WR-1:0]              we,
    input  logic [NUM_WR*$clog2(DEPTH)-1:0] waddr,
    input  logic [NUM_WR*WIDTH-1:0]        wdata,
    input  logic [NUM_RD-1:0]              re,
    input  logic [NUM_RD*$clog2(DEPTH)-1:0] raddr,
    output logic [NUM_RD*WIDTH-1:0]        rdata,
    output logic [NUM_RD-1:0]              rvalid,
    output logic                           wr_collision
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [MAX_WR-1:0]           we_vec;
    addr_vec_t                   wa_vec;
    logic                        coll_next;

    // Effective write enables; with the zero register, address-0 writes vanish here
    // so they never reach storage, collision detection or bypass.
    always_comb begin
        we_vec = '0;
        wa_vec = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            wa_vec[i] = addr_t'(waddr[i*AW +: AW]);
`ifdef MULTI_PORT_REG_FILE_ZERO_REG_EN
            we_vec[i] = we[i] && (waddr[i*AW +: AW] != '0);
`else
            we_vec[i] = we[i];
`endif
        end
    end

    always_comb begin
        coll_next = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (we_vec[i] && (count_matches(we_vec, wa_vec, wa_vec[i]) > 1)) coll_next = 1'b1;
        end
    end

    // Ascending port order: the last non-blocking write wins, i.e. the highest index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem          <= '0;
            wr_collision <= 1'b0;
        end else begin
            wr_collision <= coll_next;
            for (int i = 0; i < NUM_WR; i++) begin
                if (we_vec[i]) mem[waddr[i*AW +: AW]] <= wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        reg_file_read_port #(
            .WIDTH  (WIDTH),
            .DEPTH  (DEPTH),
            .NUM_WR (NUM_WR),
            .AW     (AW)
        ) u_rd (
            .clk    (clk),
            .reset  (reset),
            .re     (re[j]),
            .raddr  (raddr[j*AW +: AW]),
            .mem    (mem),
            .we_vec (we_vec),
            .wa_vec (wa_vec),
            .wdata  (wdata),
            .rdata  (rdata[j*WIDTH +: WIDTH]),
            .rvalid (rvalid[j])
        );
    end

endmodule

// File: tb/tb_multi_port_reg_file.sv
// Directed bench for multi_port_reg_file at default parameters (64x64, 4 read, 2 write).
module tb_multi_port_reg_file;

    localparam int W  = 64;
    localparam int AW = 6;
`ifdef MULTI_PORT_REG_FILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     we;
    logic [2*AW-1:0] waddr;
    logic [2*W-1:0] wdata;
    logic [3:0]     re;
    logic [4*AW-1:0] raddr;
    logic [4*W-1:0] rdata;
    logic [3:0]     rvalid;
    logic           wr_collision;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    multi_port_reg_file dut (
        .clk          (clk),
        .reset        (reset),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .re           (re),
        .raddr        (raddr),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .wr_collision (wr_collision)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = '0;
        re = '0;
    endtask

    task automatic wr(input int p, input int a, input logic [W-1:0] d);
        we[p]            = 1'b1;
        waddr[p*AW +: AW] = AW'(a);
        wdata[p*W +: W]   = d;
    endtask

    task automatic rd(input int p, input int a);
        re[p]             = 1'b1;
        raddr[p*AW +: AW] = AW'(a);
    endtask

    function automatic logic [W-1:0] port_data(input int p);
        return rdata[p*W +: W];
    endfunction

    task automatic check_q(input string tag, input int p);
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check(tag, port_data(p), e);
    endtask

    initial begin
        reset = 1'b0;
        we    = 2'($urandom);
        waddr = 12'($urandom);
        wdata = {$urandom, $urandom, $urandom, $urandom};
        re    = 4'($urandom);
        raddr = 24'($urandom);
        repeat (2) tick();
        check("rst_rvalid", W'(rvalid), '0);
        check("rst_coll", W'(wr_collision), '0);
        check("rst_rdata0", port_data(0), '0);
        idle();
        #2 reset = 1'b1;

        // reset and idle: read addr 0..3
        for (int p = 0; p < 4; p++) rd(p, p);
        tick();
        check("idle_rvalid", W'(rvalid), 64'hF);
        for (int p = 0; p < 4; p++) check("idle_rdata", port_data(p), '0);
        check("idle_coll", W'(wr_collision), '0);

        // basic write / read
        idle();
        wr(0, 0, 64'd100);
        wr(1, 1, 64'd75);
        tick();
        check("basic_coll", W'(wr_collision), '0);
        idle();
        for (int p = 0; p < 4; p++) rd(p, p);
        exp_q.push_back(ZR ? 64'd0 : 64'd100);
        exp_q.push_back(64'd75);
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);
        tick();
        check("basic_rvalid", W'(rvalid), 64'hF);
        for (int p = 0; p < 4; p++) check_q("basic_rdata", p);

        // read enable gating on port 1
        idle();
        rd(0, 1);
        rd(2, 1);
        rd(3, 1);
        raddr[1*AW +: AW] = AW'(2);
        tick();
        check("gate_rvalid", W'(rvalid), 64'hD);
        check("gate_hold1", port_data(1), 64'd75);
        check("gate_same0", port_data(0), 64'd75);
        check("gate_same3", port_data(3), 64'd75);

        // write collision on addr 5
        idle();
        wr(0, 5, 64'd11);
        wr(1, 5, 64'd22);
        tick();
        check("coll_pulse", W'(wr_collision), 64'd1);
        idle();
        rd(0, 5);
        tick();
        check("coll_clear", W'(wr_collision), '0);
        check("coll_winner", port_data(0), 64'd22);

        // same-data collision still flags
        idle();
        wr(0, 9, 64'd4);
        wr(1, 9, 64'd4);
        tick();
        check("coll_same", W'(wr_collision), 64'd1);

        // bypass: addr 7 holds 3, then write 9 while reading
        idle();
        wr(0, 7, 64'd3);
        tick();
        idle();
        wr(1, 7, 64'd9);
        rd(2, 7);
        rd(3, 5);
        tick();
        check("byp_rdata2", port_data(2), 64'd9);
        check("byp_other3", port_data(3), 64'd22);
        check("byp_coll", W'(wr_collision), '0);

        // bypass with conflicting writers returns the winner
        idle();
        wr(0, 8, 64'd30);
        wr(1, 8, 64'd40);
        rd(1, 8);
        tick();
        check("byp_win", port_data(1), 64'd40);
        check("byp_win_coll", W'(wr_collision), 64'd1);
        idle();
        rd(0, 7);
        tick();
        check("byp_stored", port_data(0), 64'd9);

        // zero register behaviour
        idle();
        wr(0, 0, 64'd42);
        tick();
        idle();
        rd(0, 0);
        tick();
        check("zero_rd", port_data(0), ZR ? 64'd0 : 64'd42);
        idle();
        wr(0, 0, 64'd1);
        wr(1, 0, 64'd2);
        tick();
        check("zero_coll", W'(wr_collision), ZR ? 64'd0 : 64'd1);

        // reset mid-operation
        idle();
        rd(0, 5);
        tick();
        check("pre_rst_valid", W'(rvalid[0]), 64'd1);
        rd(1, 5);
        wr(0, 6, 64'd77);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", W'(rvalid), '0);
        check("mid_rst_data", port_data(0), '0);
        idle();
        @(posedge clk);
        #3 reset = 1'b1;
        rd(0, 5);
        rd(1, 6);
        tick();
        check("post_rst_5", port_data(0), '0);
        check("post_rst_6", port_data(1), '0);
        check("post_rst_valid", W'(rvalid), 64'h3);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
